// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
//   state_t   : sequencer states
//   req_id_t  : requester index (0 = core load/store, 1 = debug/DMA loader)
//   WAIT_W    : width of the access wait counter
//   addr_err  : flags misaligned or out-of-range byte addresses
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic req_id_t;

    localparam int WAIT_W = 4;

    // A byte address is illegal when it is not word aligned or its word index
    // falls outside the memory.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant logic, purely combinational.
//   valid : request present per requester
//   last  : requester granted at the previous acceptance
//   grant : one-hot or zero
// The pointer itself lives in the sequencer, which updates it on acceptance.
import dmem_arb_pkg::*;

module rr_arb2 (
    input  logic [1:0] valid,
    input  req_id_t    last,
    output logic [1:0] grant
);

    // On contention the requester that did not win last time goes first;
    // a lone requester simply wins.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Sequencer and two-requester arbiter in front of the single-port data memory.
// Accepts one request at a time via valid/ready, drives the memory for
// 1+WAIT_CYCLES cycles, then returns a one-cycle response pulse.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/we        : per-requester request and direction (1 = write)
//   req_addr0/1         : byte addresses
//   req_wd0/1           : write data
//   req_ready           : acceptance strobe (one-hot or zero)
//   rsp_valid           : response pulse to the owning requester
//   rsp_rdata, rsp_err  : read data (0 for writes/errors) and error flag
//   mem_we/addr/wd      : memory write enable, word index, write data
//   mem_rd              : combinational memory read data
//
// state  | meaning
// IDLE   | no transaction in flight, accepting requests
// ACCESS | memory driven; waits WAIT_CYCLES extra cycles, last cycle commits
// DONE   | response pulse; may accept the next request in the same cycle
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int unsigned DEPTH       = 100,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_we,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    input  logic [31:0] req_wd0,
    input  logic [31:0] req_wd1,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    req_id_t            last_q, last_d;
    req_id_t            id_q, id_d;
    logic               we_q, we_d;
    logic               err_q, err_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wd_q, wd_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [1:0]         grant;
    req_id_t            win;
    logic               win_we;
    logic [31:0]        win_addr;
    logic [31:0]        win_wd;
    logic               accept;
    logic               final_access;

    rr_arb2 u_arb (
        .valid (req_valid),
        .last  (last_q),
        .grant (grant)
    );

    assign win      = grant[1];
    assign win_we   = win ? req_we[1] : req_we[0];
    assign win_addr = win ? req_addr1 : req_addr0;
    assign win_wd   = win ? req_wd1 : req_wd0;

    // DONE accepts exactly like IDLE so back-to-back traffic loses no cycle.
    assign accept       = ((state_q == IDLE) || (state_q == DONE)) && (grant != 2'b00) && !reset;
    assign final_access = (state_q == ACCESS) && (wait_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  if (wait_q == '0) state_d = DONE;
            DONE:    state_d = accept ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; everything is forced quiet while reset is high so a reset that
    // lands on the final access cycle suppresses the write.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_we    = 1'b0;
        if (!reset) begin
            if (accept) begin
                req_ready = grant;
            end
            if (state_q == DONE) begin
                rsp_valid[id_q] = 1'b1;
                rsp_rdata       = rdata_q;
                rsp_err         = err_q;
            end
            if (final_access) begin
                mem_we = we_q & ~err_q;
            end
        end
    end

    // The latched payload only changes on acceptance, so driving the memory
    // straight from it gives the "hold last value" behaviour outside ACCESS.
    assign mem_addr = {2'b00, addr_q[31:2]};
    assign mem_wd   = wd_q;

    // Transaction datapath
    always_comb begin
        wait_d  = wait_q;
        last_d  = last_q;
        id_d    = id_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        if (accept) begin
            id_d   = win;
            last_d = win;
            we_d   = win_we;
            addr_d = win_addr;
            wd_d   = win_wd;
            err_d  = addr_err(win_addr, DEPTH);
            wait_d = WAIT_W'(WAIT_CYCLES);
        end else if ((state_q == ACCESS) && (wait_q != '0)) begin
            wait_d = wait_q - WAIT_W'(1);
        end
        if (final_access) begin
            rdata_d = (we_q || err_q) ? '0 : mem_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q  <= '0;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
        end else begin
            wait_q  <= wait_d;
            last_q  <= last_d;
            id_q    <= id_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
